// File: rtl/pool_unit.sv
// 2x2 max-pooling stage: streams a signed feature map in raster order and emits pooled samples.
// Optional macro POOL_RELU_EN clamps every pooled sample at zero.
`timescale 1ns/1ps
module pool_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int MAP_WIDTH  = 24,
   parameter int MAP_HEIGHT = 24
) (
   input  logic                         clk,
   input  logic                         srst,
   input  logic                         pool_start,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         busy,
   output logic                         pool_done
);

   localparam int LB_DEPTH = MAP_WIDTH / 2;
   localparam int CW       = $clog2(MAP_WIDTH);
   localparam int RW       = $clog2(MAP_HEIGHT);
   localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                         state_q, state_d;
   logic [CW-1:0]                  col_q, col_d;
   logic [RW-1:0]                  row_q, row_d;
   logic signed [DATA_WIDTH-1:0]   pair_q, pair_d;
   logic signed [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                           out_valid_q, out_valid_d;
   logic                           all_in_q, all_in_d;
   logic signed [DATA_WIDTH-1:0]   lb_q [LB_DEPTH];

   logic                           accept, drain, last_col, last_px, final_hs, lb_we;
   logic [LBW-1:0]                 lb_idx;
   logic signed [DATA_WIDTH-1:0]   hmax, vmax;

   function automatic logic signed [DATA_WIDTH-1:0] smax(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] relu(
      input logic signed [DATA_WIDTH-1:0] x
   );
`ifdef POOL_RELU_EN
      return (x < 0) ? '0 : x;
`else
      return x;
`endif
   endfunction

   assign in_ready = (state_q == S_RUN) && !all_in_q && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid_q && out_ready;
   assign last_col = (col_q == CW'(MAP_WIDTH - 1));
   assign last_px  = last_col && (row_q == RW'(MAP_HEIGHT - 1));
   // all_in_q guarantees the pending output is the last one of the map
   assign final_hs = drain && all_in_q;
   assign lb_idx   = LBW'(col_q >> 1);
   assign hmax     = smax(pair_q, in_data);
   assign vmax     = smax(hmax, lb_q[lb_idx]);

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      pair_d      = pair_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      all_in_d    = all_in_q;
      lb_we       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pool_start) begin
               state_d  = S_RUN;
               col_d    = '0;
               row_d    = '0;
               all_in_d = 1'b0;
            end
         end
         S_RUN: begin
            if (drain) out_valid_d = 1'b0;
            if (accept) begin
               if (!col_q[0]) begin
                  pair_d = in_data;
               end else if (!row_q[0]) begin
                  lb_we = 1'b1;
               end else begin
                  out_data_d  = relu(vmax);
                  out_valid_d = 1'b1;
               end
               if (last_col) begin
                  col_d = '0;
                  row_d = last_px ? '0 : row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (last_px) all_in_d = 1'b1;
            end
            if (final_hs) state_d = S_DONE;
         end
         S_DONE: begin
            state_d  = S_IDLE;
            all_in_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         pair_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         all_in_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         pair_q      <= pair_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         all_in_q    <= all_in_d;
      end
   end

   // Line buffer is always written on an even row before the odd row reads it
   always_ff @(posedge clk) begin
      if (lb_we && !srst) lb_q[lb_idx] <= hmax;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q == S_RUN);
   assign pool_done = (state_q == S_DONE);

endmodule

// File: tb/tb_pool_unit.sv
// Directed bench for pool_unit: 24x24 passes with stall/reset/ignored controls, plus 4x4 and 2x2 maps.
`timescale 1ns/1ps
module tb_pool_unit;

   logic clk;
   logic srst;

   logic              s_start, s_vld, s_irdy, s_ovld, s_ordy, s_busy, s_done;
   logic signed [7:0] s_data, s_odata;
   logic              a_start, a_vld, a_irdy, a_ovld, a_ordy, a_busy, a_done;
   logic signed [7:0] a_data, a_odata;
   logic              b_start, b_vld, b_irdy, b_ovld, b_ordy, b_busy, b_done;
   logic signed [7:0] b_data, b_odata;

   int n_checks = 0;
   int n_err    = 0;

   logic signed [7:0] map24 [576];
   logic signed [7:0] exp24 [144];
   int                exp4  [4];
   logic signed [7:0] in2   [4];

   pool_unit #(.DATA_WIDTH(8), .MAP_WIDTH(24), .MAP_HEIGHT(24)) u24 (
      .clk(clk), .srst(srst), .pool_start(s_start), .in_valid(s_vld), .in_ready(s_irdy),
      .in_data(s_data), .out_valid(s_ovld), .out_ready(s_ordy), .out_data(s_odata),
      .busy(s_busy), .pool_done(s_done));

   pool_unit #(.DATA_WIDTH(8), .MAP_WIDTH(4), .MAP_HEIGHT(4)) u4 (
      .clk(clk), .srst(srst), .pool_start(a_start), .in_valid(a_vld), .in_ready(a_irdy),
      .in_data(a_data), .out_valid(a_ovld), .out_ready(a_ordy), .out_data(a_odata),
      .busy(a_busy), .pool_done(a_done));

   pool_unit #(.DATA_WIDTH(8), .MAP_WIDTH(2), .MAP_HEIGHT(2)) u2 (
      .clk(clk), .srst(srst), .pool_start(b_start), .in_valid(b_vld), .in_ready(b_irdy),
      .in_data(b_data), .out_valid(b_ovld), .out_ready(b_ordy), .out_data(b_odata),
      .busy(b_busy), .pool_done(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic signed [7:0] mx(input logic signed [7:0] a, input logic signed [7:0] b);
      return (a >= b) ? a : b;
   endfunction

   function automatic logic signed [7:0] relu_m(input logic signed [7:0] x);
`ifdef POOL_RELU_EN
      return (x < 0) ? 8'sd0 : x;
`else
      return x;
`endif
   endfunction

   task automatic gen_map24();
      int idx;
      for (int i = 0; i < 576; i++) map24[i] = 8'($urandom);
      map24[0] = -8'sd128;
      map24[2] = 8'sd127;
      map24[3] = 8'sd127;
      for (int r = 0; r < 12; r++)
         for (int c = 0; c < 12; c++) begin
            idx = 2 * r * 24 + 2 * c;
            exp24[r * 12 + c] = relu_m(mx(mx(map24[idx], map24[idx + 1]),
                                          mx(map24[idx + 24], map24[idx + 25])));
         end
   endtask

   task automatic drive24(input int n, input int pulse_at);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 20000) begin
         s_vld   = 1'b1;
         s_data  = map24[i];
         s_start = (i == pulse_at);
         #1;
         if (s_irdy) i++;
         @(negedge clk);
         guard++;
      end
      s_vld   = 1'b0;
      s_start = 1'b0;
      check("drive24_count", i, n);
   endtask

   task automatic collect24(input int nexp, input bit stall);
      int k = 0;
      int guard = 0;
      bit stalled = 1'b0;
      logic signed [7:0] held;
      while (k < nexp && guard < 40000) begin
         s_ordy = (stall && !stalled) ? 1'b0 : ($urandom_range(0, 3) != 0);
         #1;
         if (stall && !stalled && s_ovld) begin
            held = s_odata;
            check("stall_first", held, exp24[0]);
            for (int j = 0; j < 20; j++) begin
               @(negedge clk);
               #1;
               check("stall_vld", s_ovld, 1);
               check("stall_data", s_odata, held);
               check("stall_irdy", s_irdy, 0);
            end
            stalled = 1'b1;
         end else if (s_ovld && s_ordy) begin
            check("out24", s_odata, exp24[k]);
            k++;
         end
         @(negedge clk);
         guard++;
      end
      s_ordy = 1'b1;
      check("collect24_count", k, nexp);
   endtask

   task automatic done24();
      #1;
      check("done24_pulse", s_done, 1);
      check("done24_busy", s_busy, 0);
      @(negedge clk);
      #1;
      check("done24_low", s_done, 0);
      check("done24_no_extra", s_ovld, 0);
      @(negedge clk);
   endtask

   task automatic start24();
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      #1;
      check("start24_busy", s_busy, 1);
      @(negedge clk);
   endtask

   initial begin
      int i, k, cyc;
      exp4[0] = 5; exp4[1] = 7; exp4[2] = 13; exp4[3] = 15;
      in2[0] = -8'sd3; in2[1] = -8'sd1; in2[2] = -8'sd8; in2[3] = -8'sd2;
      srst = 1'b1;
      s_start = 0; s_vld = 0; s_data = 0; s_ordy = 1;
      a_start = 0; a_vld = 0; a_data = 0; a_ordy = 1;
      b_start = 0; b_vld = 0; b_data = 0; b_ordy = 1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", s_busy, 0);
      check("rst_irdy", s_irdy, 0);
      check("rst_ovld", s_ovld, 0);
      check("rst_odata", s_odata, 0);
      check("rst_done", s_done, 0);
      check("rst4_ovld", a_ovld, 0);
      check("rst2_ovld", b_ovld, 0);
      @(negedge clk);
      srst = 1'b0;

      // in_valid while idle must be refused
      s_vld = 1'b1;
      s_data = 8'sd55;
      repeat (3) begin
         @(negedge clk);
         #1;
         check("idle_irdy", s_irdy, 0);
         check("idle_ovld", s_ovld, 0);
         check("idle_busy", s_busy, 0);
      end
      @(negedge clk);
      s_vld = 1'b0;

      // Pass A: output stalled at first sample, start pulsed mid-pass
      gen_map24();
      start24();
      fork
         drive24(576, 100);
         collect24(144, 1'b1);
      join
      done24();

      // Pass B: reset after 30 inputs with outputs already produced
      gen_map24();
      start24();
      s_ordy = 1'b1;
      drive24(30, -1);
      srst  = 1'b1;
      s_vld = 1'b1;
      @(negedge clk);
      #1;
      check("mrst_busy", s_busy, 0);
      check("mrst_irdy", s_irdy, 0);
      check("mrst_ovld", s_ovld, 0);
      check("mrst_odata", s_odata, 0);
      check("mrst_done", s_done, 0);
      @(negedge clk);
      srst  = 1'b0;
      s_vld = 1'b0;
      @(negedge clk);

      // Pass C: fresh full map after the aborted one
      gen_map24();
      start24();
      fork
         drive24(576, -1);
         collect24(144, 1'b0);
      join
      done24();

      // 4x4 map with ramp 0..15
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      i = 0; k = 0; cyc = 0;
      while (k < 4 && cyc < 100) begin
         a_vld  = (i < 16);
         a_data = 8'(i);
         #1;
         if (a_ovld) begin
            check("out4", a_odata, exp4[k]);
            k++;
         end
         if (a_vld && a_irdy) i++;
         @(negedge clk);
         cyc++;
      end
      a_vld = 1'b0;
      check("out4_count", k, 4);
      #1;
      check("done4_pulse", a_done, 1);
      @(negedge clk);
      #1;
      check("done4_low", a_done, 0);
      check("done4_no_extra", a_ovld, 0);
      @(negedge clk);

      // 2x2 map of negative samples
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      i = 0; k = 0; cyc = 0;
      while (k < 1 && cyc < 50) begin
         b_vld  = (i < 4);
         b_data = in2[i % 4];
         #1;
         if (b_ovld) begin
`ifdef POOL_RELU_EN
            check("out2", b_odata, 0);
`else
            check("out2", b_odata, -1);
`endif
            k++;
         end
         if (b_vld && b_irdy) i++;
         @(negedge clk);
         cyc++;
      end
      b_vld = 1'b0;
      check("out2_count", k, 1);
      #1;
      check("done2_pulse", b_done, 1);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pool_unit.md
POOL_UNIT -- requirements
Module: pool_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8, signed feature-map sample width.
REQ-002 Parameter MAP_WIDTH, default 24, input map columns; SHALL be even and at least 2.
REQ-003 Parameter MAP_HEIGHT, default 24, input map rows; SHALL be even and at least 2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 srst  input  1  synchronous reset, active high.
REQ-006 pool_start  input  1  one-cycle pulse; arms one map pass.
REQ-007 in_valid  input  1  in_data carries a sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_data  input  DATA_WIDTH  signed conv output sample, raster order (row-major, column 0 first).
REQ-010 out_valid  output  1  out_data holds a pooled sample.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  DATA_WIDTH  signed 2x2 max-pooled sample, raster order.
REQ-013 busy  output  1  high in RUN.
REQ-014 pool_done  output  1  one-cycle pulse after the last pooled sample is accepted downstream.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on pool_start; RUN->DONE when the final output handshake occurs; DONE->IDLE unconditionally after 1 cycle.
REQ-016 A sample is accepted iff in_valid and in_ready are high; in_ready SHALL be high only in RUN, and only when (!out_valid || out_ready), and low after the last input is accepted.
REQ-017 Column counter (0..MAP_WIDTH-1) and row counter (0..MAP_HEIGHT-1) SHALL advance per accepted sample; column wraps to 0 and row increments at MAP_WIDTH-1.
REQ-018 Even column: sample SHALL be held in a pair register; odd column: horizontal max of pair register and sample formed.
REQ-019 Even row: horizontal max SHALL be written to line-buffer entry col/2 (MAP_WIDTH/2 entries).
REQ-020 Odd row: out_data SHALL be loaded with the max of the horizontal max and line-buffer entry col/2, and out_valid SHALL be set on the cycle after acceptance (latency 1).
REQ-021 Comparisons SHALL be signed two's complement; equal values yield that value.
REQ-022 out_valid SHALL stay set and out_data stable until out_ready is high; simultaneous drain and load in the same cycle SHALL be permitted.
REQ-023 Output count SHALL be (MAP_WIDTH/2)*(MAP_HEIGHT/2); pool_done fires on the final output handshake cycle +1.
REQ-024 pool_start while in RUN or DONE SHALL be ignored.
REQ-025 in_valid outside RUN SHALL be ignored (in_ready low).

Reset
REQ-026 srst high at any clock edge SHALL force IDLE, zero counters, pair register and out_data, and drive in_ready, out_valid, busy and pool_done low; this applies mid-pass and discards any partial map.
REQ-027 Line-buffer contents need not be cleared; they SHALL be rewritten before being read in every pass.

Configuration
REQ-028 Macro POOL_RELU_EN: when defined, out_data SHALL be max(pooled, 0); when undefined, out_data SHALL be the raw signed pooled max.

Verification
REQ-029 4x4 map, inputs 0..15 in raster order, out_ready=1 -> outputs 5,7,13,15, then pool_done 1 cycle after 15 is accepted.
REQ-030 2x2 map, inputs -3,-1,-8,-2: without POOL_RELU_EN -> -1; with POOL_RELU_EN -> 0.
REQ-031 24x24 map, out_ready held low after the first output -> out_valid stays high with a stable value, in_ready low; release -> 144 outputs total, all matching the reference model.
REQ-032 srst asserted after 30 inputs of a 24x24 pass -> next cycle IDLE, all outputs 0; new pool_start plus a full map -> correct 144 outputs.
REQ-033 pool_start pulsed mid-pass and in_valid pulsed in IDLE -> no counter change, no extra outputs.
